router_req_arbiter: RTL and testbench
=====================================

// Module: router_req_arbiter
// PURPOSE
//   Shares the single router instance between NUM_REQ requesters. Each requester offers a (src,dst) route job via valid/ready.
//   The block grants jobs round-robin and issues a one-cycle router_start_req with the latched addresses.
//   It holds the addresses stable until router_done, then returns a per-requester completion pulse.
//   Sits between the requesting masters and the router's start/done control interface.
// PARAMETERS
//   NUM_REQ      4     number of requesters (2..8)
//   ADDR_W       10    width of router_scr_addr / router_dst_addr
//   TIMEOUT_CYC  1024  WAIT-state watchdog limit in cycles (used only with ROUTER_TIMEOUT_EN)
// PORTS
//   clk               in   1               system clock
//   rst               in   1               synchronous, active-high reset
//   req_valid         in   NUM_REQ         requester i has a job pending
//   req_ready         out  NUM_REQ         job of requester i accepted this cycle (one-hot or zero)
//   req_src_addr      in   NUM_REQ*ADDR_W  packed source addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_dst_addr      in   NUM_REQ*ADDR_W  packed destination addresses, same packing
//   rsp_done          out  NUM_REQ         1-cycle pulse: job of requester i finished
//   rsp_err           out  NUM_REQ         1-cycle pulse with rsp_done: job aborted by watchdog
//   router_start_req  out  1               1-cycle start pulse to router
//   router_scr_addr   out  ADDR_W          latched source address to router
//   router_dst_addr   out  ADDR_W          latched destination address to router
//   router_done       in   1               router completion, sampled only in WAIT
//   busy              out  1               high in any state other than IDLE
//   cur_owner         out  $clog2(NUM_REQ) index of the current/last granted requester
// BEHAVIOUR
//   - Reset values:
//     - outputs: req_ready, rsp_done, rsp_err, router_start_req, busy = 0; router_*_addr = 0; cur_owner = 0.
//     - internal: state = IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
//   - FSM IDLE -> START -> WAIT -> RESP -> IDLE.
//   - IDLE:
//     - Round-robin pick g = first i with req_valid[i], searching from ptr+1 with modulo NUM_REQ wrap.
//     - req_ready[g] = 1 combinationally when any req_valid is high. Handshake completes at the clock edge.
//     - On that edge: latch addresses of g, cur_owner <= g, ptr <= g, go to START.
//   - START: router_start_req = 1 for exactly one cycle, then go to WAIT.
//   - WAIT: addresses held stable. When router_done = 1, go to RESP.
//   - RESP: rsp_done[cur_owner] = 1 for one cycle, then go to IDLE.
//   - req_ready is 0 in every state except IDLE. A requester whose req_valid stays high re-arbitrates there.
//   - router_done outside WAIT is ignored, including a done arriving in the START cycle.
//   - Minimum job period is 4 cycles: accept, START, WAIT with done, RESP.
//   - Simultaneous requests: at most one grant per job, in strict rotation from the last owner.
//     A requester cannot win twice in a row while another is valid.
//   - req_valid dropping while the job is in START/WAIT/RESP does not affect the in-flight job.
//   - Reset mid-job: immediate return to IDLE next cycle. No rsp_done is issued for the aborted job.
// CONFIGURATION
//   - Macro ROUTER_TIMEOUT_EN defined:
//     - A cycle counter runs in WAIT.
//     - If it reaches TIMEOUT_CYC without router_done, go to RESP with rsp_done[cur_owner] = 1 and rsp_err[cur_owner] = 1.
//     - If router_done and the timeout occur on the same cycle, done wins and rsp_err = 0.
//     - A late router_done after timeout is ignored.
//   - Macro not defined: no counter; WAIT exits only on router_done; rsp_err is tied to 0.
// STRUCTURE
//   - Package router_arb_pkg:
//     - state enum (IDLE, START, WAIT, RESP) and default ADDR_W = 10.
//     - TIMEOUT_CYC default.
//   - Sub-module rr_arbiter (NUM_REQ):
//     - Inputs: req vector, pointer, enable. Outputs: one-hot grant, encoded index.
//     - Combinational; the pointer register lives in the top.
// TESTING
//   1. Single job:
//      - Stimulus: req_valid = 0001, src = 10'h005, dst = 10'h3A0; router_done 6 cycles after start.
//      - Expect: ready[0] in cycle 0; start with addrs 005/3A0 in cycle 1; rsp_done[0] one cycle after done.
//   2. All four valid continuously, router_done 2 cycles after each start.
//      - Expect: grant order 0,1,2,3,0; exactly one start per job.
//   3. Stray done:
//      - Stimulus: router_done pulsed in IDLE and in the START cycle.
//      - Expect: no state change; job completes only on the later done in WAIT.
//   4. Reset mid-job: rst asserted in WAIT with owner 2.
//      - Expect: next cycle busy = 0, no rsp_done.
//      - Expect: after release, requester 0 wins a fresh 0111 request.
//   5. ROUTER_TIMEOUT_EN, TIMEOUT_CYC = 16, router_done never asserted:
//      - Expect: rsp_done[1] and rsp_err[1] in RESP 16 cycles into WAIT.
//      - Expect: a later router_done is ignored.
//      - Without the macro, the same stimulus keeps busy = 1 indefinitely.
//   6. Address isolation: change req_src_addr of the owner while in WAIT.
//      - Expect: router_scr_addr unchanged until the next grant.

Source files
------------

// File: rtl/router_arb_pkg.sv
// router_arb_pkg: shared state encoding and defaults for the router request arbiter.
package router_arb_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_TIMEOUT_CYC = 1024;
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
endpackage

// File: rtl/router_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first valid requester after ptr with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);
  logic [IDX_W-1:0] pos;
  // Scan farthest-first so the nearest valid requester after ptr is the last to win.
  always_comb begin
    idx = '0;
    pos = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[pos]) idx = pos;
    end
    grant = (en && |req) ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/router_req_arbiter.sv
// router_req_arbiter: round-robin sharing of one router among requesters.
// Define ROUTER_TIMEOUT_EN to add a WAIT-state watchdog that aborts the job with rsp_err.
module router_req_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_src_addr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dst_addr,
  output logic [NUM_REQ-1:0]        rsp_done,
  output logic [NUM_REQ-1:0]        rsp_err,
  output logic                      router_start_req,
  output logic [ADDR_W-1:0]         router_scr_addr,
  output logic [ADDR_W-1:0]         router_dst_addr,
  input  logic                      router_done,
  output logic                      busy,
  output logic [IDX_W-1:0]          cur_owner
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("router_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end
  state_t state, state_nxt;
  logic [IDX_W-1:0] ptr, gidx;
  logic [NUM_REQ-1:0] grant;
  logic timeout;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req  (req_valid),
    .ptr  (ptr),
    .en   (state == IDLE && !rst),
    .grant(grant),
    .idx  (gidx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IDX_W'(NUM_REQ - 1);
      cur_owner <= '0;
      router_scr_addr <= '0;
      router_dst_addr <= '0;
    end else begin
      state <= state_nxt;
      if (|grant) begin
        ptr <= gidx;
        cur_owner <= gidx;
        router_scr_addr <= req_src_addr[int'(gidx)*ADDR_W +: ADDR_W];
        router_dst_addr <= req_dst_addr[int'(gidx)*ADDR_W +: ADDR_W];
      end
    end
  end
`ifdef ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic err_q;
  assign timeout = state == WAIT && cnt == CNT_W'(TIMEOUT_CYC - 1);
  // Leaving WAIT without done can only mean the watchdog fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + CNT_W'(1) : '0;
      if (state == WAIT) err_q <= !router_done;
    end
  end
  assign rsp_err = err_q ? rsp_done : '0;
`else
  assign timeout = 1'b0;
  assign rsp_err = '0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = |grant ? START : IDLE;
      START: state_nxt = WAIT;
      WAIT: state_nxt = (router_done || timeout) ? RESP : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  assign req_ready = grant;
  assign router_start_req = state == START;
  assign busy = state != IDLE;
  assign rsp_done = state == RESP ? NUM_REQ'(1) << cur_owner : '0;
endmodule

// File: tb/tb_router_req_arbiter.sv
// tb_router_req_arbiter: randomized scoreboard bench; grants predicted from round-robin rules.
// Honours ROUTER_TIMEOUT_EN to expect the watchdog abort.
module tb_router_req_arbiter;
  localparam int N = 4;
  localparam int AW = 10;
  localparam int TO = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0;
  logic [N*AW-1:0] req_src_addr = '0, req_dst_addr = '0;
  logic auto_rt = 0, auto_done = 0, man_done = 0;
  logic router_done;
  logic [N-1:0] req_ready, rsp_done, rsp_err;
  logic router_start_req, busy;
  logic [AW-1:0] router_scr_addr, router_dst_addr;
  logic [1:0] cur_owner;
  int vectors = 0, miscompares = 0;
  typedef struct {int g; logic [AW-1:0] s; logic [AW-1:0] d;} job_t;
  job_t q[$];
  router_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .router_start_req(router_start_req),
    .router_scr_addr(router_scr_addr), .router_dst_addr(router_dst_addr),
    .router_done(router_done), .busy(busy), .cur_owner(cur_owner)
  );
  always #5 clk = ~clk;
  assign router_done = auto_rt ? auto_done : man_done;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set_req(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d);
    req_src_addr[i*AW +: AW] = s;
    req_dst_addr[i*AW +: AW] = d;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Monitor: job phase model (0 idle, 1 start, 2 wait, 3 resp) advanced once per cycle.
  initial begin
    int m = 0, owner = 0, last = N - 1, cnt = 0, pg = 0;
    bit pgv = 0, prst = 1, err = 0, pdone = 0, found;
    logic [AW-1:0] hs = '0, hd = '0;
    job_t j;
    forever begin
      @(negedge clk);
      if (prst) begin
        m = 0; owner = 0; last = N - 1; hs = '0; hd = '0; q.delete();
      end else if (m == 0) begin
        if (pgv) begin m = 1; owner = pg; end
      end else if (m == 1) begin
        m = 2; cnt = 0;
      end else if (m == 2) begin
        if (pdone) begin
          m = 3; err = 0;
        end else begin
          cnt++;
`ifdef ROUTER_TIMEOUT_EN
          if (cnt == TO) begin m = 3; err = 1; end
`endif
        end
      end else m = 0;
      if (m == 1 && q.size() > 0) begin
        j = q.pop_front();
        hs = j.s; hd = j.d;
      end
      check("busy", busy, m != 0);
      check("start", router_start_req, m == 1);
      check("cur_owner", cur_owner, owner);
      check("src_addr", router_scr_addr, hs);
      check("dst_addr", router_dst_addr, hd);
      check("rsp_done", rsp_done, m == 3 ? 1 << owner : 0);
      check("rsp_err", rsp_err, (m == 3 && err) ? 1 << owner : 0);
      pgv = 0;
      if (m == 0 && !rst && |req_valid) begin
        found = 0;
        for (int k = 1; k <= N; k++)
          if (!found && req_valid[(last + k) % N]) begin
            pg = (last + k) % N;
            found = 1;
          end
        pgv = 1;
        last = pg;
        q.push_back('{pg, req_src_addr[pg*AW +: AW], req_dst_addr[pg*AW +: AW]});
      end
      check("req_ready", req_ready, pgv ? 1 << pg : 0);
      pdone = router_done;
      prst = rst;
    end
  end
  // Router responder: done 1..5 cycles into WAIT, plus stray pulses in START/IDLE/RESP.
  initial begin
    int cd = 0;
    forever begin
      tick();
      if (rst) cd = 0;
      if (router_start_req) begin
        cd = $urandom_range(1, 5);
        auto_done = 1'($urandom_range(0, 1));
      end else if (cd > 0) begin
        cd--;
        auto_done = cd == 0;
      end else auto_done = $urandom_range(0, 7) == 0;
    end
  end
  initial begin
    logic [N-1:0] pend, rs;
    repeat (3) tick();
    rst = 0;
    man_done = 1;
    tick();
    man_done = 0;
    set_req(0, 10'h005, 10'h3A0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    man_done = 1;
    tick();
    man_done = 0;
    repeat (5) tick();
    man_done = 1;
    tick();
    man_done = 0;
    repeat (3) tick();
    set_req(1, 10'h111, 10'h222);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (40) tick();
    man_done = 1;
    tick();
    man_done = 0;
    repeat (3) tick();
    set_req(2, 10'h0AA, 10'h155);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (2) tick();
    set_req(2, 10'h3FF, 10'h001);
    repeat (2) tick();
    rst = 1;
    tick();
    rst = 0;
    req_valid = 4'b0111;
    tick();
    auto_rt = 1;
    req_valid = 4'b1111;
    repeat (30) tick();
    pend = req_valid;
    repeat (2000) begin
      @(negedge clk);
      rs = req_ready;
      tick();
      pend = req_valid & ~rs;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          set_req(i, AW'($urandom), AW'($urandom));
        end else if (pend[i] && $urandom_range(0, 29) == 0) pend[i] = 0;
      end
      req_valid = pend;
    end
    req_valid = '0;
    repeat (20) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
